// File: rtl/pwm_pkg.sv
// Shared PWM types and register-select encodings; the generator and the capture block use the same sel map.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } cap_state_t;

   localparam logic [1:0] SEL_STAT = 2'd0;
   localparam logic [1:0] SEL_HI   = 2'd1;
   localparam logic [1:0] SEL_PER  = 2'd2;
   localparam logic [1:0] SEL_CNT  = 2'd3;

   localparam int STAT_VALID = 0;
   localparam int STAT_OVF   = 1;
   localparam int STAT_LVL   = 2;

endpackage

// File: rtl/pwm_capture_if.sv
// Control-bus view of the PWM capture block: input waveform, clear strobe and register readback.
interface pwm_capture_if #(
   parameter int W = 16
) ();
   logic         pwm_in;
   logic         clr;
   logic [1:0]   sel;
   logic [W-1:0] q;
   logic         valid;
   logic         ovf;

   modport master (
      output pwm_in, clr, sel,
      input  q, valid, ovf
   );

   modport slave (
      input  pwm_in, clr, sel,
      output q, valid, ovf
   );
endinterface

// File: rtl/pwm_in_filter.sv
// Input conditioning: 2-flop synchronizer, optional glitch filter (PWM_CAP_FILTER_EN), edge detect.
// Edges appear 3 clocks after pwm_in moves, FILT_LEN-1 more with the filter.
module pwm_in_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic nrst,
   input  logic pwm_in,
   output logic s,
   output logic rise,
   output logic fall
);

   if (FILT_LEN < 2) begin : g_bad_len
      $error("FILT_LEN must be at least 2");
   end

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;
   logic filt_lvl;

`ifdef PWM_CAP_FILTER_EN
   localparam int CW = $clog2(FILT_LEN + 1);

   logic          filt_q, filt_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic          differ;
   logic          flip;

   // The output follows in the same cycle the FILT_LEN-th differing sample is
   // seen, so the filter adds FILT_LEN-1 clocks rather than FILT_LEN.
   always_comb begin
      differ   = (sync2_q != filt_q);
      flip     = differ && (fcnt_q == CW'(FILT_LEN - 1));
      filt_lvl = flip ? sync2_q : filt_q;
      filt_d   = filt_lvl;
      fcnt_d   = (differ && !flip) ? fcnt_q + CW'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end
`else
   always_comb filt_lvl = sync2_q;
`endif

   always_comb begin
      sync1_d = pwm_in;
      sync2_d = sync1_q;
      prev_d  = filt_lvl;
      s       = filt_lvl;
      rise    = filt_lvl & ~prev_q;
      fall    = ~filt_lvl & prev_q;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time (hi = H) and period (per = P-1) of pwm_in in generator register encoding.
// Optional glitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int W        = 16,
   parameter int FILT_LEN = 3
) (
   input  logic          clk,
   input  logic          nrst,
   pwm_capture_if.slave  bus
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic s, rise, fall;

   pwm_in_filter #(.FILT_LEN(FILT_LEN)) u_in (
      .clk    (clk),
      .nrst   (nrst),
      .pwm_in (bus.pwm_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );

   cap_state_t   state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] hi_tmp_q, hi_tmp_d;
   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] per_q, per_d;
   logic         valid_q, valid_d;
   logic         ovf_q, ovf_d;

   logic [W-1:0] cnt_inc;
   logic         at_max;
   logic         timeout;

   always_comb begin
      at_max  = (cnt_q == CNT_MAX);
      cnt_inc = at_max ? cnt_q : cnt_q + W'(1);
      timeout = at_max && (((state_q == HIGH) && !fall) || ((state_q == LOW) && !rise));
   end

   always_ff @(posedge clk) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = HIGH;
         HIGH:    if (fall) state_d = LOW;  else if (at_max) state_d = IDLE;
         LOW:     if (rise) state_d = HIGH; else if (at_max) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      hi_tmp_d = hi_tmp_q;
      hi_d     = hi_q;
      per_d    = per_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: cnt_d = '0;
         HIGH: begin
            cnt_d = cnt_inc;
            if (fall) hi_tmp_d = cnt_inc;
         end
         LOW: begin
            if (rise) begin
               // hi and per move together so a readback never pairs two periods.
               hi_d    = hi_tmp_q;
               per_d   = cnt_q;
               cnt_d   = '0;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: cnt_d = '0;
      endcase
      if (timeout) begin
         cnt_d   = '0;
         ovf_d   = 1'b1;
         valid_d = 1'b0;
      end
      // clr only touches the reported results; timing of the current period carries on.
      if (bus.clr) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
         hi_d    = '0;
         per_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_q    <= '0;
         hi_tmp_q <= '0;
         hi_q     <= '0;
         per_q    <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_tmp_q <= hi_tmp_d;
         hi_q     <= hi_d;
         per_q    <= per_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      bus.q     = '0;
      bus.valid = valid_q;
      bus.ovf   = ovf_q;
      case (bus.sel)
         SEL_STAT: begin
            bus.q[STAT_VALID] = valid_q;
            bus.q[STAT_OVF]   = ovf_q;
            bus.q[STAT_LVL]   = s;
         end
         SEL_HI:   bus.q = hi_q;
         SEL_PER:  bus.q = per_q;
         SEL_CNT:  bus.q = cnt_q;
         default:  bus.q = '0;
      endcase
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed waveforms drive the capture block; the monitor checks each change of the reported result set.
module tb_pwm_capture;
   import pwm_pkg::*;

   localparam int W    = 8;
   localparam int FILT = 3;
`ifdef PWM_CAP_FILTER_EN
   localparam int RISE_LAT = 3 + FILT - 1;
`else
   localparam int RISE_LAT = 3;
`endif

   typedef struct packed {
      logic         valid;
      logic         ovf;
      logic         st_valid;
      logic         st_ovf;
      logic [W-1:0] hi;
      logic [W-1:0] per;
   } snap_t;

   logic clk;
   logic nrst;
   int   checks = 0;
   int   errors = 0;
   snap_t exp_q[$];

   pwm_capture_if #(.W(W)) bus ();

   pwm_capture #(.W(W), .FILT_LEN(FILT)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic snap_t mk(input logic v, input logic o, input int h, input int p);
      snap_t r;
      r.valid    = v;
      r.ovf      = o;
      r.st_valid = v;
      r.st_ovf   = o;
      r.hi       = W'(h);
      r.per      = W'(p);
      return r;
   endfunction

   task automatic seg(input logic lvl, input int n);
      bus.pwm_in = lvl;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic period(input int h, input int p);
      seg(1'b1, h);
      seg(1'b0, p - h);
   endtask

   // Raises clr exactly on the clock where this period's opening rise commits.
   task automatic period_clr(input int h, input int p);
      bus.pwm_in = 1'b1;
      for (int i = 0; i < p; i++) begin
         if (i == h) bus.pwm_in = 1'b0;
         bus.clr = (i == RISE_LAT - 1);
         @(posedge clk);
         #1;
      end
      bus.clr = 1'b0;
   endtask

   // Monitor: owns sel, snapshots all readback registers each negedge.
   initial begin
      snap_t cur, prev, exp;
      bit    first = 1'b1;
      bus.sel = SEL_STAT;
      @(posedge clk);
      forever begin
         @(negedge clk);
         bus.sel = SEL_STAT;
         #1;
         cur.valid    = bus.valid;
         cur.ovf      = bus.ovf;
         cur.st_valid = bus.q[STAT_VALID];
         cur.st_ovf   = bus.q[STAT_OVF];
         bus.sel = SEL_HI;
         #1;
         cur.hi = bus.q;
         bus.sel = SEL_PER;
         #1;
         cur.per = bus.q;
         bus.sel = SEL_STAT;
         if (first || cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change t=%0t got v=%0b o=%0b sv=%0b so=%0b hi=%0d per=%0d want no change",
                        $time, cur.valid, cur.ovf, cur.st_valid, cur.st_ovf, cur.hi, cur.per);
            end else begin
               exp = exp_q.pop_front();
               if (cur != exp) begin
                  errors++;
                  $display("FAIL result_set t=%0t got v=%0b o=%0b sv=%0b so=%0b hi=%0d per=%0d want v=%0b o=%0b sv=%0b so=%0b hi=%0d per=%0d",
                           $time, cur.valid, cur.ovf, cur.st_valid, cur.st_ovf, cur.hi, cur.per,
                           exp.valid, exp.ovf, exp.st_valid, exp.st_ovf, exp.hi, exp.per);
               end
            end
         end
         prev  = cur;
         first = 1'b0;
      end
   end

   initial begin
      nrst       = 1'b0;
      bus.pwm_in = 1'b0;
      bus.clr    = 1'b0;
      exp_q.push_back(mk(0, 0, 0, 0));
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b1;
      seg(1'b0, 3);

      // Steady 4/10 waveform: first rise only arms, second commits, third is unchanged.
      period(4, 10);
      exp_q.push_back(mk(1, 0, 4, 9));
      period(4, 10);
      period(4, 10);

      // Duty change 4 -> 7 appears as one atomic jump.
      period(7, 10);
      exp_q.push_back(mk(1, 0, 7, 9));
      period(7, 10);

      // clr coinciding with a commit wins; next period commits normally.
      exp_q.push_back(mk(0, 0, 0, 0));
      period_clr(7, 10);
      exp_q.push_back(mk(1, 0, 7, 9));
      period(7, 10);

      // Reset in LOW discards everything; two fresh rises needed.
      exp_q.push_back(mk(0, 0, 0, 0));
      seg(1'b1, 4);
      seg(1'b0, 3);
      nrst = 1'b0;
      seg(1'b0, 1);
      nrst = 1'b1;
      seg(1'b0, 3);
      period(4, 10);
      exp_q.push_back(mk(1, 0, 4, 9));
      period(4, 10);

      // High phase with a 2-clock low glitch, 12-clock period overall.
`ifdef PWM_CAP_FILTER_EN
      exp_q.push_back(mk(1, 0, 8, 11));
`else
      exp_q.push_back(mk(1, 0, 3, 4));
      exp_q.push_back(mk(1, 0, 3, 6));
`endif
      seg(1'b1, 3);
      seg(1'b0, 2);
      seg(1'b1, 3);
      seg(1'b0, 4);
      period(4, 10);
      exp_q.push_back(mk(1, 0, 4, 9));
      period(4, 10);

      // Input stuck high: counter saturates, ovf set, valid dropped, results kept.
      exp_q.push_back(mk(0, 1, 4, 9));
      seg(1'b1, 300);
      seg(1'b0, 10);
      exp_q.push_back(mk(0, 0, 0, 0));
      bus.clr = 1'b1;
      @(posedge clk);
      #1;
      bus.clr = 1'b0;
      seg(1'b0, 3);

      // Recovery from IDLE after a timeout.
      period(4, 10);
      exp_q.push_back(mk(1, 0, 4, 9));
      period(4, 10);
      seg(1'b0, 10);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations got %0d outstanding want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator. Measures an incoming PWM waveform and reports its high time and period.
- Results use the generator's register encoding: high count maps to cmp, period-1 maps to top. A captured value can therefore be written straight back into a generator.
- Readback uses the same 2-bit sel register-select style as the generator. Sits beside the PWM blocks on the control bus.

Parameters:
- W, 16, counter and result width in bits
- FILT_LEN, 3, glitch-filter stability length in clocks (used only with PWM_CAP_FILTER_EN)

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  synchronous active-low reset
- pwm_in  input  1  asynchronous PWM input
- clr  input  1  clears valid, ovf and results; one-cycle pulse
- sel  input  2  read select: 0 status, 1 high, 2 period, 3 live counter
- q  output  W  read data selected by sel, combinational from registers
- valid  output  1  high and period registers hold a coherent complete measurement
- ovf  output  1  sticky timeout: counter saturated without an edge

Behaviour:
- Reset: one clock and reset domain; reset is synchronous, active-low, on nrst. While nrst=0 at a clk edge, all of the following load 0: state=IDLE, cnt, hi_tmp, hi, per, valid, ovf, and both synchronizer flops.
- Input path: 2-flop synchronizer, then a previous-level flop. Edges: rise = s & ~s_d, fall = ~s & s_d. An edge is visible 3 clocks after pwm_in changes.
- State IDLE: cnt held at 0. On rise: cnt <= 0, go to HIGH.
- State HIGH: cnt <= cnt+1 each clock, saturating. On fall: hi_tmp <= cnt+1 (saturating), cnt <= cnt+1, go to LOW.
- State LOW: cnt <= cnt+1 each clock. On rise:
  - hi <= hi_tmp, per <= cnt, cnt <= 0, valid <= 1, stay in HIGH path (go to HIGH).
  - hi and per always commit in the same cycle, so a read never mixes two periods.
  - Resulting encoding for a waveform with period P clocks and high time H clocks: per = P-1, hi = H.
- Timeout: if cnt reaches 2^W-1 in HIGH or LOW with no edge that cycle: ovf <= 1, valid <= 0, go to IDLE. This covers 0% and 100% duty and lost input. hi and per keep their last values.
- clr: valid <= 0, ovf <= 0, hi <= 0, per <= 0. Measurement state is not touched.
  - clr together with a LOW-state rise: clr wins for valid/hi/per. The FSM still restarts cnt and goes to HIGH.
  - clr together with a timeout: ovf ends at 0, state goes to IDLE.
- First edge after reset or IDLE: the first rise only starts timing. valid rises on the second rise, after a full period.
- Read mux:
  - sel=0: q = {0..., s, ovf, valid} (bit2 = synced level)
  - sel=1: q = hi
  - sel=2: q = per
  - sel=3: q = cnt
- Reset mid-measurement discards all partial and committed results.

Optional Feature:
- PWM_CAP_FILTER_EN defined:
  - A filter sits between the synchronizer and edge detect. Its output changes only after the synced input holds a new level for FILT_LEN consecutive clocks.
  - Pulses shorter than FILT_LEN are ignored.
  - Edge latency becomes 3+FILT_LEN-1 clocks. Both edges are delayed equally, so hi and per are unchanged for clean inputs.
  - The filter counter resets to 0, and the filter output resets to 0.
- Not defined: no filter; edge detect runs directly on the synchronizer output.

Decomposition:
- Package pwm_pkg:
  - enum cap_state_t {IDLE, HIGH, LOW}
  - sel encoding constants SEL_STAT=0, SEL_HI=1, SEL_PER=2, SEL_CNT=3 (shared with the generator)
  - status bit index constants
- One natural sub-module: pwm_in_filter, containing the synchronizer, optional glitch filter and edge detect. Outputs: s, rise, fall.

Test Plan:
- Generator-style waveform, period 10, high 4, repeated 3 times -> after the 2nd rise: valid=1, sel=1 gives q=4, sel=2 gives q=9. Values stay stable across later periods.
- pwm_in held 1 forever after one rise (W=8 build for speed) -> after 255 counts: ovf=1, valid=0, state IDLE, sel=0 gives bit1=1.
- clr pulsed on the same cycle as a commit-causing rise -> valid=0, hi=per=0. The following period commits normally (valid=1 one period later).
- nrst=0 asserted mid-LOW with valid=1 -> next cycle all outputs 0. Two fresh rises are needed before valid=1.
- Duty change from high 4 to high 7 at period 10 -> at the commit after the change, hi jumps 4→7 with per=9. hi and per never show a mixed pair.
- With PWM_CAP_FILTER_EN and FILT_LEN=3: a 2-clock low glitch inside a high phase -> no fall detected, hi unchanged. Without the macro the same stimulus gives a short hi.
